sat_trunc_reg: RTL
==================

# sat_trunc_reg

Registered truncate-and-saturate stage that sits directly downstream of the round-to-zero stage in the fixed-point datapath. It drops the NBITS low bits the rounder has already zeroed, saturates the remaining value into a narrower DOUT-bit word, and re-times the valid/ready handshake through a two-entry skid buffer. The stage runs at full throughput with one cycle of latency. It also keeps a saturating count of clipped samples for software.

## Interface
- NBITS, 0: number of LSBs dropped by an arithmetic (SIGNED=1) or logical (SIGNED=0) right shift; 0 ≤ NBITS < DIN.
- DIN, 16: input word width.
- DOUT, 8: output word width; DOUT ≥ 1.
- SIGNED, 1: 1 means two's-complement data; 0 means unsigned data.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- din_valid  input  1  upstream data valid.
- din_ready  output  1  stage can accept data.
- din_data  input  DIN  rounded input sample.
- dout_valid  output  1  output data valid.
- dout_ready  input  1  downstream can accept data.
- dout_data  output  DOUT  truncated, saturated sample.
- sat_clr  input  1  synchronous clear of sat_cnt.
- sat_cnt  output  16  number of saturated samples accepted; sticks at 0xFFFF.

## Operation
- Transfer rules:
  - An input transfer happens when din_valid && din_ready.
  - An output transfer happens when dout_valid && dout_ready.
- Arithmetic on each accepted sample:
  - s = din_data >> NBITS, arithmetic if SIGNED, otherwise logical. W = DIN−NBITS bits.
  - If W ≤ DOUT: dout_data = s, sign-extended (SIGNED) or zero-extended.
  - If W > DOUT and SIGNED: the limits are MAX = 2^(DOUT−1)−1 and MIN = −2^(DOUT−1).
    - s > MAX gives MAX.
    - s < MIN gives MIN.
    - Otherwise dout_data = s[DOUT-1:0].
  - If W > DOUT and unsigned: s > 2^DOUT−1 gives all ones; otherwise dout_data = s[DOUT-1:0].
  - The saturation flag is set only when clipping actually occurred. The computed result and flag are registered together with the data.
- Skid buffer states:
  - EMPTY: no data held. Accept goes to ONE.
  - ONE: output register valid.
    - Accept without output transfer goes to TWO; the new sample is written to the skid register.
    - Output transfer without accept goes to EMPTY.
    - Both together stay in ONE; the output register is loaded with the new sample.
  - TWO: output register and skid register both valid.
    - din_ready = 0.
    - An output transfer moves skid into output and goes to ONE.
- din_ready is a register: 1 in EMPTY and ONE, 0 in TWO. It is never combinationally dependent on dout_ready.
- Ordering: samples leave in acceptance order; no sample is dropped or duplicated.
- dout_data is stable while dout_valid && !dout_ready.
- sat_cnt:
  - Increments by 1 on each input transfer whose sample saturates; it stays at 0xFFFF once reached.
  - sat_clr takes priority: when asserted the counter becomes 0, and a simultaneous saturation event is not counted.

## Timing
- Reset values while rst is low: dout_valid=0, din_ready=0, sat_cnt=0, dout_data=0, state EMPTY.
- din_ready rises to 1 on the first rising clk edge after rst deasserts. It is held at 0 during reset so no transfer can occur.
- Reset asserted mid-operation: both buffered samples are discarded immediately and all outputs take their reset values asynchronously.
- Latency: a sample accepted at edge k appears on dout_data with dout_valid=1 after edge k, i.e. in cycle k+1.
- Throughput: with dout_ready held at 1, one sample per cycle is sustained indefinitely.
- Backpressure:
  - dout_ready low for N ≥ 2 cycles: exactly two samples are absorbed, and din_ready is 0 from the cycle after the second accept.
  - din_ready returns to 1 the cycle after the first output transfer.
- sat_cnt updates one cycle after the accepting edge, in the same cycle dout_data for that sample becomes visible.

## Test plan
- Config DIN=16, NBITS=8, DOUT=4, SIGNED=1, dout_ready=1. Input 0x0300, 0x7F00, 0x8000, 0xFD00 on consecutive cycles.
  - Required dout_data: 0x3, 0x7, 0x8, 0xD, each one cycle after accept.
  - Required sat_cnt: 0, 1, 2, 2.
- Same config, SIGNED=0. Input 0x0F00, then 0x1000.
  - Required dout_data: 0xF, then 0xF.
  - Required sat_cnt: 0, then 1.
- Backpressure: stream 0x0100..0x0600 with dout_ready low for 4 cycles after the first output.
  - din_ready drops after two buffered accepts.
  - Outputs are 1..6 in order with no loss or duplication.
  - dout_data stays stable while stalled.
- Random din_valid/dout_ready toggling over 10,000 samples, compared against a scoreboard: order preserved, and sat_cnt matches the reference count.
- Reset: assert rst low in state TWO.
  - dout_valid and din_ready go to 0 immediately, without waiting for clk.
  - After release, din_ready returns to 1 one cycle later, and the first new sample emerges with no stale data.
- Counter: force 65,537 saturating samples; sat_cnt holds 0xFFFF. Then sat_clr asserted together with a saturating accept gives sat_cnt=0.

Source files
------------

// File: rtl/sat_trunc_reg_if.sv
// Purpose: valid/ready data channel used on both sides of sat_trunc_reg.
// Latency: none, it only bundles wires.
// Backpressure: the master drives valid/data; the slave drives ready.
// Signals: valid (data present), ready (sink can take data), data [W-1:0].
interface sat_trunc_reg_if #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/sat_trunc_reg.sv
// Purpose: drop NBITS LSBs, saturate into DOUT bits, count clipped samples.
// Latency: one cycle from accepting edge to dout valid; full throughput.
// Backpressure: two-entry skid buffer; din.ready is registered, never combinational on dout.ready.
// Ports: clk, rst (async active-low), din (slave, DIN bits), dout (master, DOUT bits),
//        sat_clr (sync clear of sat_cnt), sat_cnt (16-bit sticky-saturating clip count).
module sat_trunc_reg #(
  parameter int NBITS  = 0,
  parameter int DIN    = 16,
  parameter int DOUT   = 8,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  sat_trunc_reg_if.slave    din,
  sat_trunc_reg_if.master   dout,
  input  logic              sat_clr,
  output logic [15:0]       sat_cnt
);

  localparam int W = DIN - NBITS;

  logic [DIN-1:0]  sh;
  logic [DOUT-1:0] res;
  logic            sat;

  // Separate assignments keep the arithmetic shift in a signed context.
  always_comb begin
    if (SIGNED != 0) sh = $signed(din.data) >>> NBITS;
    else             sh = din.data >> NBITS;
  end

  generate
    if (W <= DOUT) begin : g_fit
      if (DOUT > DIN) begin : g_ext
        assign res = {{(DOUT-DIN){(SIGNED != 0) && sh[DIN-1]}}, sh};
      end else begin : g_cut
        // sh is already sign/zero extended to DIN bits, so the low DOUT bits suffice.
        logic unused_hi;
        assign unused_hi = ^sh;
        assign res = sh[DOUT-1:0];
      end
      assign sat = 1'b0;
    end else if (SIGNED != 0) begin : g_ssat
      // Value fits in DOUT signed bits iff all bits from DOUT-1 upward agree.
      logic [DIN-DOUT:0] top;
      logic              fits;
      assign top  = sh[DIN-1:DOUT-1];
      assign fits = (&top) | ~(|top);
      always_comb begin
        res = sh[DOUT-1:0];
        sat = 1'b0;
        if (!fits) begin
          sat = 1'b1;
          res = top[DIN-DOUT] ? (DOUT'(1) << (DOUT-1)) : ~(DOUT'(1) << (DOUT-1));
        end
      end
    end else begin : g_usat
      logic over;
      assign over = |sh[DIN-1:DOUT];
      assign res  = over ? {DOUT{1'b1}} : sh[DOUT-1:0];
      assign sat  = over;
    end
  endgenerate

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state, state_nxt;
  logic            rdy_q;
  logic [DOUT-1:0] out_q, skid_q;
  logic            vld, acc, ox;
  logic            ld_out_in, ld_out_skid, ld_skid;

  assign vld = (state != EMPTY);
  assign acc = din.valid && rdy_q;
  assign ox  = vld && dout.ready;

  always_comb begin
    state_nxt   = state;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          ld_out_in = 1'b1;
        end
      end
      ONE: begin
        case ({acc, ox})
          2'b10: begin
            state_nxt = TWO;
            ld_skid   = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: ld_out_in = 1'b1;
          default: state_nxt = ONE;
        endcase
      end
      TWO: begin
        // din.ready is low here, so no accept can coincide.
        if (ox) begin
          state_nxt   = ONE;
          ld_out_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != TWO);
      if (ld_out_in)        out_q <= res;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= res;
    end
  end

  // Clip counter: clear wins over a coincident clip; sticks at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (acc && sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign din.ready  = rdy_q;
  assign dout.valid = vld;
  assign dout.data  = out_q;

endmodule
